// File: rtl/psum_drain_pkg.sv
// Shared constants, FSM encoding and byte-beat payload for the psum drain path.
package psum_drain_pkg;

  localparam int unsigned NUM_COLS  = 32;
  localparam int unsigned ADDR_PSUM = 12;
  localparam int unsigned PSUM_BW   = 32;
  localparam int unsigned OUT_BW    = 8;
  localparam int unsigned ROW_W     = $clog2(NUM_COLS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } state_e;

  typedef struct packed {
    logic              last;
    logic [OUT_BW-1:0] data;
  } beat_t;

endpackage

// File: rtl/psum_requant.sv
// Pure combinational 32->8 requantizer: round-half-up shift, optional ReLU, saturate.
module psum_requant
  import psum_drain_pkg::*;
(
  input  logic [PSUM_BW-1:0] psum,
  input  logic [4:0]         shift,
  input  logic               relu_en,
  output logic [OUT_BW-1:0]  q_c
);

  localparam int unsigned EXT_W = PSUM_BW + 1;

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] rnd;
  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] shr;

  // Extra headroom bit keeps the rounding add from overflowing.
  always_comb begin
    ext = $signed({psum[PSUM_BW-1], psum});
    rnd = '0;
    if (shift != 5'd0) begin
      rnd = $signed(EXT_W'(1) << (shift - 5'd1));
    end
    sum = ext + rnd;
    shr = sum >>> shift;
    if (relu_en && shr[EXT_W-1]) begin
      shr = '0;
    end
    if (shr > 33'sd127) begin
      q_c = 8'h7F;
    end else if (shr < -33'sd128) begin
      q_c = 8'h80;
    end else begin
      q_c = shr[OUT_BW-1:0];
    end
  end

endmodule

// File: rtl/psum_drain.sv
// Drains psums row by row from the PSUM_ROW_MEMs, requantizes, and streams bytes out.
module psum_drain
  import psum_drain_pkg::*;
(
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic [5:0]                  OUT_H,
  input  logic [5:0]                  OUT_W,
  input  logic [7:0]                  OC,
  input  logic [4:0]                  SHIFT,
  input  logic                        RELU_EN,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_COLS-1:0]         psum_rd_en,
  output logic [ADDR_PSUM-1:0]        psum_rd_addr,
  input  logic [PSUM_BW*NUM_COLS-1:0] psum_rd_data,
  output logic [OUT_BW-1:0]           m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last
);

  state_e               state_q, state_d;
  logic [5:0]           h_q;
  logic [ADDR_PSUM-1:0] len_q;
  logic [4:0]           shift_q;
  logic                 relu_q;
  logic [ROW_W-1:0]     row_q;
  logic [ADDR_PSUM-1:0] addr_q;
  logic                 rd_vld_q;
  logic                 rd_last_q;
  logic [ROW_W-1:0]     rd_col_q;
  beat_t                skid_q;
  logic                 skid_vld_q;

  logic [13:0]          len_full_c;
  logic                 cfg_zero_c;
  logic                 pop_c;
  logic [1:0]           inflight_c;
  logic                 issue_c;
  logic                 last_elem_c;
  logic [PSUM_BW-1:0]   lane_c;
  logic [OUT_BW-1:0]    rq_c;
  beat_t                push_c;

  assign len_full_c  = 14'(OUT_W) * 14'(OC);
  assign cfg_zero_c  = (OUT_H == 6'd0) || (OUT_W == 6'd0) || (OC == 8'd0);
  assign pop_c       = m_valid & m_ready;
  // Bytes held in the FIFO plus the one read that may be returning this cycle.
  assign inflight_c  = 2'(m_valid) + 2'(skid_vld_q) + 2'(rd_vld_q);
  assign issue_c     = (state_q == RUN) && ((inflight_c - 2'(pop_c)) < 2'd2);
  assign last_elem_c = (row_q == ROW_W'(h_q - 6'd1)) && (addr_q == len_q - ADDR_PSUM'(1));

  assign psum_rd_en   = issue_c ? (NUM_COLS'(1) << row_q) : '0;
  assign psum_rd_addr = addr_q;

  assign lane_c = psum_rd_data[rd_col_q*PSUM_BW +: PSUM_BW];
  assign push_c = '{last: rd_last_q, data: rq_c};

  psum_requant u_requant (
    .psum    (lane_c),
    .shift   (shift_q),
    .relu_en (relu_q),
    .q_c     (rq_c)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; FLUSH exits once nothing is returning and the FIFO drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = cfg_zero_c ? FIN : RUN;
      RUN:     if (issue_c && last_elem_c) state_d = FLUSH;
      FLUSH:   if (!rd_vld_q && !skid_vld_q && (!m_valid || pop_c)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered status flags decoded from the upcoming state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_d == RUN) || (state_d == FLUSH);
      done <= (state_d == FIN);
    end
  end

  // Config latch and row/address walk; address wraps into the next row.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_q     <= '0;
      len_q   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      row_q   <= '0;
      addr_q  <= '0;
    end else if ((state_q == IDLE) && start) begin
      h_q     <= OUT_H;
      len_q   <= ADDR_PSUM'(len_full_c);
      shift_q <= SHIFT;
      relu_q  <= RELU_EN;
      row_q   <= '0;
      addr_q  <= '0;
    end else if (issue_c && !last_elem_c) begin
      if (addr_q == len_q - ADDR_PSUM'(1)) begin
        addr_q <= '0;
        row_q  <= row_q + ROW_W'(1);
      end else begin
        addr_q <= addr_q + ADDR_PSUM'(1);
      end
    end
  end

  // Tracks the single outstanding read and which lane it will return on.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      rd_col_q  <= '0;
    end else begin
      rd_vld_q  <= issue_c;
      rd_last_q <= issue_c && last_elem_c;
      if (issue_c) rd_col_q <= row_q;
    end
  end

  // Two-entry FIFO: output register is the head, skid holds the second byte.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else if (!m_valid || pop_c) begin
      if (skid_vld_q) begin
        m_data     <= skid_q.data;
        m_last     <= skid_q.last;
        m_valid    <= 1'b1;
        skid_vld_q <= rd_vld_q;
        if (rd_vld_q) skid_q <= push_c;
      end else if (rd_vld_q) begin
        m_data  <= push_c.data;
        m_last  <= push_c.last;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
    end else if (rd_vld_q) begin
      skid_q     <= push_c;
      skid_vld_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: stimulus pushes expected bytes, a monitor pops and checks.
module tb_psum_drain;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [5:0]    out_h, out_w;
  logic [7:0]    oc;
  logic [4:0]    shift;
  logic          relu_en;
  logic          busy, done;
  logic [31:0]   psum_rd_en;
  logic [11:0]   psum_rd_addr;
  logic [1023:0] psum_rd_data;
  logic [7:0]    m_data;
  logic          m_valid, m_ready, m_last;

  int   mem [0:31][0:63];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   lat_exp_cyc  = -1;
  int   exp_done_cyc = -1;
  bit   done_seen = 0;
  bit   quiet     = 0;
  bit   rand_rdy  = 0;
  int   issued    = 0;
  int   hs_count  = 0;
  bit   stall     = 0;
  logic [7:0] st_data;
  logic       st_last;

  psum_drain dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .OUT_H        (out_h),
    .OUT_W        (out_w),
    .OC           (oc),
    .SHIFT        (shift),
    .RELU_EN      (relu_en),
    .busy         (busy),
    .done         (done),
    .psum_rd_en   (psum_rd_en),
    .psum_rd_addr (psum_rd_addr),
    .psum_rd_data (psum_rd_data),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference requantizer written with plain integer arithmetic.
  function automatic logic [7:0] ref_q(input int p, input int sh, input bit relu);
    longint v;
    v = longint'(p);
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic last);
    exp_q.push_back('{d: d, last: last});
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++)
      for (int a = 0; a < 64; a++)
        mem[i][a] = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 8000)) - 4000;
  endtask

  task automatic do_start(input int h, input int w, input int c, input int sh, input bit relu,
                          input bit use_model);
    @(posedge clk); #1;
    if (use_model)
      for (int r = 0; r < h; r++)
        for (int a = 0; a < w * c; a++)
          push_exp(ref_q(mem[r][a], sh, relu), (r == h - 1) && (a == w * c - 1));
    if (h * w * c == 0) exp_done_cyc = cyc + 1;
    else                lat_exp_cyc  = cyc + 3;
    done_seen = 0;
    out_h = 6'(h); out_w = 6'(w); oc = 8'(c); shift = 5'(sh); relu_en = relu;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", 64'(done_seen), 64'(1));
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    repeat (2) @(posedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy",    64'(busy),         64'(0));
    chk("rst_done",    64'(done),         64'(0));
    chk("rst_m_valid", 64'(m_valid),      64'(0));
    chk("rst_m_last",  64'(m_last),       64'(0));
    chk("rst_rd_en",   64'(psum_rd_en),   64'(0));
    chk("rst_rd_addr", 64'(psum_rd_addr), 64'(0));
    chk("rst_m_data",  64'(m_data),       64'(0));
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // PSUM_ROW_MEM model: one-cycle read latency, only enabled lanes update.
  initial begin
    psum_rd_data = '0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 32; i++)
        if (psum_rd_en[i]) psum_rd_data[i*32 +: 32] <= mem[i][psum_rd_addr[5:0]];
    end
  end

  // Downstream ready, optionally randomized.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stream/flow rules.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!resetn) begin
      stall = 0; issued = 0; hs_count = 0;
    end else begin
      if (stall)
        chk("hold_stable", 64'({m_valid, m_last, m_data}), 64'({1'b1, st_last, st_data}));
      if (m_valid && lat_exp_cyc >= 0) begin
        chk("first_valid_cycle", 64'(cyc), 64'(lat_exp_cyc));
        lat_exp_cyc = -1;
      end
      if (m_valid && m_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h, none expected (cycle %0d)", m_data, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("byte_data", 64'(m_data), 64'(e.d));
          chk("byte_last", 64'(m_last), 64'(e.last));
          if (e.last) exp_done_cyc = cyc + 1;
        end
      end
      stall   = m_valid && !m_ready;
      st_data = m_data;
      st_last = m_last;
      if (done || cyc == exp_done_cyc) begin
        chk("done_timing", 64'(done), 64'(cyc == exp_done_cyc));
        if (done) done_seen = 1;
      end
      if (psum_rd_en != '0) begin
        issued++;
        chk("rd_en_onehot", 64'($onehot(psum_rd_en)), 64'(1));
        chk("inflight_le2", 64'((issued - hs_count) <= 2), 64'(1));
      end
      if (quiet) chk("quiet_outputs", 64'({m_valid, |psum_rd_en}), 64'(0));
    end
  end

  initial begin
    int h, w, c, sh, base;
    bit relu;
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int h, w, c, sh, base, n;
    bit relu;
    resetn = 1'b0; start = 1'b0;
    out_h = '0; out_w = '0; oc = '0; shift = '0; relu_en = 1'b0;
    for (int i = 0; i < 32; i++)
      for (int a = 0; a < 64; a++) mem[i][a] = 0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Basic two-byte drain with full throughput.
    mem[0][0] = 5; mem[0][1] = -3;
    push_exp(8'd5, 1'b0); push_exp(8'hFD, 1'b1);
    do_start(1, 1, 2, 0, 1'b0, 1'b0);
    wait_done(50);
    chk("idle_busy", 64'(busy), 64'(0));

    // Rounding and saturation.
    mem[0][0] = 24; mem[0][1] = 23; mem[0][2] = -24; mem[0][3] = 3000; mem[0][4] = -3000;
    push_exp(8'd2, 0); push_exp(8'd1, 0); push_exp(8'hFF, 0); push_exp(8'h7F, 0); push_exp(8'h80, 1);
    do_start(1, 1, 5, 4, 1'b0, 1'b0);
    wait_done(60);

    // ReLU clamp.
    mem[0][0] = -50; mem[0][1] = 40;
    push_exp(8'd0, 0); push_exp(8'd40, 1);
    do_start(1, 1, 2, 0, 1'b1, 1'b0);
    wait_done(50);

    // Multi-row ordering under random backpressure.
    rand_rdy = 1;
    for (int r = 0; r < 3; r++)
      for (int a = 0; a < 4; a++) begin
        mem[r][a] = r * 16 + a;
        push_exp(8'(r * 16 + a), (r == 2) && (a == 3));
      end
    do_start(3, 2, 2, 0, 1'b0, 1'b0);
    wait_done(200);

    // Zero-size config: done one cycle after start, no reads or bytes.
    quiet = 1;
    do_start(2, 3, 0, 0, 1'b0, 1'b0);
    wait_done(20);
    repeat (3) @(posedge clk);
    quiet = 0;

    // Randomized drains against the reference model.
    for (int k = 0; k < 6; k++) begin
      h = (k == 0) ? 32 : $urandom_range(1, 8);
      w = $urandom_range(1, 4);
      c = $urandom_range(1, 8);
      sh = $urandom_range(0, 20);
      relu = 1'($urandom_range(0, 1));
      rand_rdy = 1'(k % 2);
      fill_random();
      do_start(h, w, c, sh, relu, 1'b1);
      wait_done(h * w * c * 8 + 50);
    end

    // Reset mid-drain, then a fresh drain with an ignored start while busy.
    rand_rdy = 1;
    fill_random();
    base = hs_count;
    do_start(4, 2, 4, 3, 1'b0, 1'b1);
    n = 0;
    while (hs_count < base + 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("five_bytes_before_reset", 64'(hs_count >= base + 5), 64'(1));
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    lat_exp_cyc = -1;
    exp_done_cyc = -1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    quiet = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_busy", 64'(busy), 64'(0));
    quiet = 0;
    fill_random();
    do_start(4, 2, 4, 3, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_mid_drain", 64'(busy), 64'(1));
    out_h = 6'd1; out_w = 6'd1; oc = 8'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
